// File: rtl/enc_np_pkg.sv
// Shared types and word-format helpers for the parametrised row encoder.
// Covers the encoder FSM state, the word prefixes and the marker/width functions.
package enc_np_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_WAIT = 2'd2
    } enc_state_e;

    localparam logic PFX_RAW    = 1'b0;
    localparam logic PFX_TAGGED = 1'b1;

    // Upper bound on the encoded word width that the helpers below can describe.
    localparam int MAX_W = 64;

    function automatic int word_width(input int pix_w, input int n_pix);
        return 1 + pix_w * n_pix;
    endfunction

    // The marker word is the tag bit above an all-zero field that is f bits wide.
    function automatic logic [MAX_W-1:0] marker_word(input int f);
        logic [MAX_W-1:0] w;
        w    = '0;
        w[f] = PFX_TAGGED;
        return w;
    endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Synchronous show-ahead FIFO. rd_data shows the head entry, or zero when the FIFO is empty.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
module enc_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/row_encoder_np.sv
// Row encoder: packs pixel rows, suppresses repeats, time-stamps wake-ups and emits epoch words.
// Events go into two pair slots (SAMPLE, EPOCH) that drain into a show-ahead output FIFO.
module row_encoder_np
    import enc_np_pkg::*;
#(
    parameter int PIX_W        = 3,
    parameter int N_PIX        = 5,
    parameter int TS_W         = 45,
    parameter int FIFO_DEPTH   = 4,
    parameter int EPOCH_ALWAYS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_valid,
    input  logic [N_PIX*PIX_W-1:0] pixel_in,
    input  logic [TS_W-1:0]        tik_tok,
    output logic [N_PIX*PIX_W:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [1:0]             state_dbg
);

    localparam int W = word_width(PIX_W, N_PIX);
    localparam int F = W - 1;
    localparam logic [MAX_W-1:0] MARKER_FULL = marker_word(F);
    localparam logic [W-1:0]     MARKER      = MARKER_FULL[W-1:0];

    if (TS_W < 2 * F) begin : g_ts_w_check
        $error("row_encoder_np: TS_W must be at least 2*N_PIX*PIX_W");
    end

    if (TS_W > 2 * F) begin : g_ts_hi
        logic ts_hi_unused;
        assign ts_hi_unused = ^tik_tok[TS_W-1:2*F];
    end

    logic           dv_q;
    logic           sample;
    enc_state_e     state_q, state_d;
    logic [F-1:0]   last_pix_q, last_pix_d;
    logic           s_evt, s_evt_ts, e_evt;

    assign sample    = data_valid && !dv_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d    = state_q;
        last_pix_d = last_pix_q;
        s_evt      = 1'b0;
        s_evt_ts   = 1'b0;
        e_evt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample) begin
                    s_evt      = 1'b1;
                    s_evt_ts   = 1'b1;
                    last_pix_d = pixel_in;
                    state_d    = ST_PUSH;
                end
            end
            ST_PUSH: begin
                e_evt = (EPOCH_ALWAYS != 0) && (&tik_tok[F-1:0]);
                if (sample) begin
                    if (pixel_in != last_pix_q) begin
                        s_evt      = 1'b1;
                        last_pix_d = pixel_in;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                e_evt = &tik_tok[F-1:0];
                if (sample && (pixel_in != last_pix_q)) begin
                    s_evt      = 1'b1;
                    s_evt_ts   = 1'b1;
                    last_pix_d = pixel_in;
                    state_d    = ST_PUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot state: each pair slot remembers which of its two words is still pending.
    logic         s_busy_q, s_ts_pend_q;
    logic [W-1:0] s_ts_word_q, s_raw_word_q;
    logic         e_busy_q, e_mark_pend_q;
    logic [W-1:0] e_word_q;
    logic         e_older_q;

    logic         fifo_full, fifo_empty;
    logic         pick_s, pick_e, serve_s, serve_e, s_done, e_done;
    logic         s_set, e_set, s_drop, e_drop;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic [1:0]   drop_inc;
    logic [8:0]   drop_sum;

    // Serving strictly by age also keeps a started pair ahead of anything queued after it.
    assign pick_e  = e_busy_q && (!s_busy_q || e_older_q);
    assign pick_s  = s_busy_q && !pick_e;
    assign serve_s = pick_s && !fifo_full;
    assign serve_e = pick_e && !fifo_full;
    assign s_done  = serve_s && !s_ts_pend_q;
    assign e_done  = serve_e && !e_mark_pend_q;
    assign wr_en   = serve_s || serve_e;
    assign wr_data = pick_e ? (e_mark_pend_q ? MARKER : e_word_q)
                            : (s_ts_pend_q ? s_ts_word_q : s_raw_word_q);

    // A slot whose final word is being written this cycle can take a new event.
    assign s_set    = s_evt && (!s_busy_q || s_done);
    assign e_set    = e_evt && (!e_busy_q || e_done);
    assign s_drop   = s_evt && !s_set;
    assign e_drop   = e_evt && !e_set;
    assign drop_inc = {1'b0, s_drop} + {1'b0, e_drop};
    assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q          <= 1'b0;
            state_q       <= ST_IDLE;
            last_pix_q    <= '0;
            s_busy_q      <= 1'b0;
            s_ts_pend_q   <= 1'b0;
            s_ts_word_q   <= '0;
            s_raw_word_q  <= '0;
            e_busy_q      <= 1'b0;
            e_mark_pend_q <= 1'b0;
            e_word_q      <= '0;
            e_older_q     <= 1'b0;
            overflow      <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            dv_q       <= data_valid;
            state_q    <= state_d;
            last_pix_q <= last_pix_d;

            if (s_set) begin
                s_busy_q     <= 1'b1;
                s_ts_pend_q  <= s_evt_ts;
                s_ts_word_q  <= {PFX_TAGGED, tik_tok[F-1:0]};
                s_raw_word_q <= {PFX_RAW, pixel_in};
            end else if (serve_s) begin
                if (s_ts_pend_q) s_ts_pend_q <= 1'b0;
                else             s_busy_q    <= 1'b0;
            end

            if (e_set) begin
                e_busy_q      <= 1'b1;
                e_mark_pend_q <= 1'b1;
                e_word_q      <= {PFX_TAGGED, tik_tok[2*F-1:F] + F'(1)};
            end else if (serve_e) begin
                if (e_mark_pend_q) e_mark_pend_q <= 1'b0;
                else               e_busy_q      <= 1'b0;
            end

            // A same-cycle arrival in both slots leaves SAMPLE as the older one.
            if (s_set) begin
                e_older_q <= e_busy_q && !e_done;
            end else if (e_set) begin
                e_older_q <= 1'b0;
            end

            if (s_drop || e_drop) begin
                overflow <= 1'b1;
                drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    // out_valid/out_ready: a word transfers on a rising edge where both are high;
    // until then out_data holds the same head word.
    enc_out_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_row_encoder_np.sv
// Self-checking bench for row_encoder_np with default parameters (W=16, F=15).
// Expected words are queued as stimulus is driven and compared as the sink accepts them.
module tb_row_encoder_np;

    localparam int W    = 16;
    localparam int TS_W = 45;
    localparam logic [TS_W-1:0] SAFE_TS = 45'h0000_1234_0005;

    logic              clk;
    logic              rst;
    logic              data_valid;
    logic [W-2:0]      pixel_in;
    logic [TS_W-1:0]   tik_tok;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic [1:0]        state_dbg;

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    row_encoder_np dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .pixel_in   (pixel_in),
        .tik_tok    (tik_tok),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // One clock: the sink observes on the falling edge, inputs change 1 time unit after rising.
    task automatic tick();
        logic [W-1:0] exp;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra got=%h expected=none", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL scoreboard_word got=%h expected=%h", out_data, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [W-2:0] pix, input logic [TS_W-1:0] ts, input int gap);
        data_valid = 1'b1;
        pixel_in   = pix;
        tik_tok    = ts;
        tick();
        data_valid = 1'b0;
        tik_tok    = SAFE_TS;
        repeat (gap) tick();
    endtask

    task automatic pulse_ts(input logic [TS_W-1:0] ts);
        tik_tok = ts;
        tick();
        tik_tok = SAFE_TS;
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst        = 1'b1;
        data_valid = 1'b0;
        out_ready  = 1'b1;
        tik_tok    = SAFE_TS;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        out_ready  = 1'b1;
        pixel_in   = '0;
        tik_tok    = SAFE_TS;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h expected=0000", out_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d expected=0", drop_cnt); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d expected=0", state_dbg); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        exp_q.push_back(16'h8ABC);
        exp_q.push_back(16'h1111);
        send_sample(15'h1111, 45'h0000_0000_0ABC, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_t1 got=%b expected=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h8ABC) begin failures++; $display("FAIL basic_ts_t2 got=%b/%h expected=1/8abc", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111) begin failures++; $display("FAIL basic_raw_t3 got=%b/%h expected=1/1111", out_valid, out_data); end
        repeat (2) tick();
        exp_q.push_back(16'h2222);
        send_sample(15'h2222, SAFE_TS, 3);
        exp_q.push_back(16'h3333);
        send_sample(15'h3333, SAFE_TS, 3);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_repeat();
        do_reset();
        exp_q.push_back(16'h8005);
        exp_q.push_back(16'h1111);
        send_sample(15'h1111, SAFE_TS, 3);
        exp_q.push_back(16'h2222);
        send_sample(15'h2222, SAFE_TS, 3);
        send_sample(15'h2222, SAFE_TS, 3);
        checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL repeat_wait_state got=%0d expected=2", state_dbg); end
        send_sample(15'h2222, SAFE_TS, 3);
        exp_q.push_back(16'h8123);
        exp_q.push_back(16'h4444);
        send_sample(15'h4444, 45'h0000_1230_0123, 3);
        checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL repeat_push_state got=%0d expected=1", state_dbg); end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL repeat_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_epoch();
        do_reset();
        pulse_ts(45'h7FFF);
        repeat (4) tick();
        exp_q.push_back(16'h8005);
        exp_q.push_back(16'h0001);
        send_sample(15'h0001, SAFE_TS, 3);
        send_sample(15'h0001, SAFE_TS, 3);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h8001);
        pulse_ts(45'h7FFF);
        repeat (4) tick();
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h8006);
        pulse_ts(45'h2FFFF);
        repeat (4) tick();
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h8000);
        pulse_ts(45'h100_3FFF_FFFF);
        repeat (4) tick();
        exp_q.push_back(16'h8005);
        exp_q.push_back(16'h0002);
        send_sample(15'h0002, SAFE_TS, 3);
        pulse_ts(45'h7FFF);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (6) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL epoch_drain got=%0d expected=0", exp_q.size()); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL epoch_push_silent got=%b expected=0", out_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        exp_q.push_back(16'h8005);
        exp_q.push_back(16'h0010);
        send_sample(15'h0010, SAFE_TS, 3);
        send_sample(15'h0010, SAFE_TS, 3);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0020);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h800A);
        send_sample(15'h0020, 45'h4FFFF, 0);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL simul_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_q.push_back(16'h8005);
        exp_q.push_back(16'h0100);
        send_sample(15'h0100, SAFE_TS, 3);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_prefill_drain got=%0d expected=0", exp_q.size()); end
        out_ready = 1'b0;
        // Four words fit the FIFO and one waits in the slot; the other five samples are lost.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 5) exp_q.push_back(16'h0200 + 16'(k));
            send_sample(15'h0200 + 15'(k), SAFE_TS, 1);
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b expected=1", overflow); end
        checks++; if (drop_cnt !== 8'd5) begin failures++; $display("FAIL bp_drop_cnt got=%0d expected=5", drop_cnt); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0201) begin failures++; $display("FAIL bp_head got=%b/%h expected=1/0201", out_valid, out_data); end
        send_sample(15'h020A, SAFE_TS, 3);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h8004);
        pulse_ts(45'h1FFFF);
        repeat (3) tick();
        pulse_ts(45'h1FFFF);
        repeat (3) tick();
        checks++; if (drop_cnt !== 8'd6) begin failures++; $display("FAIL bp_epoch_drop got=%0d expected=6", drop_cnt); end
        send_sample(15'h0333, 45'h1FFFF, 3);
        checks++; if (drop_cnt !== 8'd8) begin failures++; $display("FAIL bp_double_drop got=%0d expected=8", drop_cnt); end
        checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL bp_dropped_state got=%0d expected=1", state_dbg); end
        checks++; if (out_data !== 16'h0201) begin failures++; $display("FAIL bp_head_stable got=%h expected=0201", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(16'h8005);
        for (int k = 1; k <= 300; k++) begin
            if (k <= 4) exp_q.push_back(16'(k));
            send_sample(15'(k), SAFE_TS, 2);
        end
        checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL sat_drop_cnt got=%0d expected=255", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%b expected=1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sat_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_pair();
        send_sample(15'd300, SAFE_TS, 3);
        send_sample(15'h0555, 45'h0000_0000_0777, 0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h8777) begin failures++; $display("FAIL midpair_ts got=%b/%h expected=1/8777", out_valid, out_data); end
        rst = 1'b1;
        exp_q.delete();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midpair_out_valid got=%b expected=0", out_valid); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL midpair_drop_cnt got=%0d expected=0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midpair_overflow got=%b expected=0", overflow); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL midpair_state got=%0d expected=0", state_dbg); end
        rst        = 1'b0;
        data_valid = 1'b1;
        pixel_in   = 15'h0666;
        tik_tok    = 45'h0000_0000_0999;
        exp_q.push_back(16'h8999);
        exp_q.push_back(16'h0666);
        tick();
        data_valid = 1'b0;
        tik_tok    = SAFE_TS;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midpair_drain got=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        data_valid = 1'b0;
        out_ready  = 1'b1;
        pixel_in   = '0;
        tik_tok    = SAFE_TS;
        test_reset();
        test_basic();
        test_repeat();
        test_epoch();
        test_simultaneous();
        test_backpressure();
        test_saturation();
        test_reset_mid_pair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
